// File: rtl/txrxsync_arb_if.sv
// Bundle between core-side requesters, the txrxsync transmit port and txrxsync_arb.
// The slave modport is the arbiter's view; master is the requester/txrxsync side.
interface txrxsync_arb_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        err;
    logic                   busy;
    logic [2:0]             grant_id;
    logic [DATA_W-1:0]      sdata;
    logic                   vi;
    logic                   snt;

    modport master (
        output req, req_data, snt,
        input  ack, err, busy, grant_id, sdata, vi
    );

    modport slave (
        input  req, req_data, snt,
        output ack, err, busy, grant_id, sdata, vi
    );
endinterface

// File: rtl/txrxsync_arb.sv
// Round-robin arbiter sharing one txrxsync transmit port among NREQ requesters.
// Issues the winner's word with a one-cycle vi, waits for snt (or timeout), reports ack/err.
module txrxsync_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic           clk_tx,
    input  logic           reset,
    txrxsync_arb_if.slave  bus
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, state_n;
    logic [2:0]          ptr, ptr_n;
    logic [2:0]          grant, grant_n;
    logic [TW-1:0]       timer, timer_n;
    logic [DATA_W-1:0]   sdata, sdata_n;
    logic                vi, vi_n;
    logic                busy, busy_n;
    logic [NREQ-1:0]     ack, ack_n;
    logic [NREQ-1:0]     err, err_n;

    logic                found;
    logic [2:0]          win;
    logic [2*NREQ-1:0]   dbl;
    logic [NREQ-1:0]     rot;
    logic [NREQ-1:0]     sh;

    // Rotate req so the pointer position sits at bit 0, then take the lowest set bit.
    always_comb begin
        found = 1'b0;
        win   = '0;
        dbl   = {bus.req, bus.req} >> ptr;
        rot   = dbl[NREQ-1:0];
        sh    = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            sh = rot >> j;
            if (!found && sh[0]) begin
                found = 1'b1;
                win   = 3'((32'(ptr) + j) % NREQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant;
        timer_n = timer;
        sdata_n = sdata;
        ack_n   = '0;
        err_n   = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = win;
                    sdata_n = DATA_W'(bus.req_data >> (32'(win) * DATA_W));
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.snt) begin
                    ack_n   = NREQ'(1) << grant;
                    state_n = DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_n   = NREQ'(1) << grant;
                    state_n = DONE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                ptr_n   = 3'((32'(grant) + 1) % NREQ);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered against the state being entered, so they line up with it.
        vi_n   = (state_n == ISSUE);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk_tx) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            timer <= '0;
            sdata <= '0;
            vi    <= 1'b0;
            busy  <= 1'b0;
            ack   <= '0;
            err   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            grant <= grant_n;
            timer <= timer_n;
            sdata <= sdata_n;
            vi    <= vi_n;
            busy  <= busy_n;
            ack   <= ack_n;
            err   <= err_n;
        end
    end

    assign bus.ack      = ack;
    assign bus.err      = err;
    assign bus.busy     = busy;
    assign bus.grant_id = grant;
    assign bus.sdata    = sdata;
    assign bus.vi       = vi;
endmodule
